axi_arbiter_w: RTL
==================

// Module: axi_arbiter_w
// PURPOSE
// - Write-channel arbiter for the 2-master AXI interconnect. Produces the one-hot m0_wgrnt/m1_wgrnt
//   that steers the downstream write-channel master mux.
// - Holds a grant for one complete write transaction: AW handshake, all W beats, then B handshake.
// - Checks the W beat count against AWLEN and flags WLAST mismatches.
// PARAMETERS
// - RR_EN        1   1: round-robin, last owner loses priority; 0: fixed priority, m0 wins
// - LEN_WIDTH    8   width of AWLEN; the beat counter is LEN_WIDTH+1 bits
// PORTS
// - ACLK         in   1          clock; all logic on rising edge
// - ARESET       in   1          synchronous reset, active-high
// - m0_AWVALID   in   1          master 0 write request (AW valid)
// - m1_AWVALID   in   1          master 1 write request
// - s_AWVALID    in   1          muxed AWVALID (granted master)
// - s_AWLEN      in   LEN_WIDTH  muxed AWLEN
// - m_AWREADY    in   1          slave-side AWREADY
// - s_WVALID     in   1          muxed WVALID
// - s_WLAST      in   1          muxed WLAST
// - m_WREADY     in   1          slave-side WREADY
// - m_BVALID     in   1          slave-side BVALID
// - s_BREADY     in   1          muxed BREADY
// - m0_wgrnt     out  1          grant to master 0 (registered)
// - m1_wgrnt     out  1          grant to master 1 (registered)
// - w_busy       out  1          a transaction is in flight (state != IDLE)
// - wlast_err    out  1          1-cycle pulse on a WLAST / AWLEN mismatch
// BEHAVIOUR
// - Reset: state=IDLE; both grants=0; w_busy=0; wlast_err=0; last_owner=m1 (m0 wins the first tie);
//   aw_done=0, w_done=0, beat_cnt=0, len_q=0.
// - Handshakes: aw_hs = s_AWVALID&m_AWREADY; w_hs = s_WVALID&m_WREADY; b_hs = m_BVALID&s_BREADY.
// - IDLE: a request is mN_AWVALID only; WVALID alone never requests.
//   - One request: grant that master next cycle (1-cycle grant latency).
//   - Both requests: RR_EN=1 grants the master that is not last_owner; RR_EN=0 grants m0.
//   - Grant registers are set on the IDLE->XFER edge; last_owner is updated at the same time.
// - XFER: the grant is held.
//   - aw_hs sets aw_done and latches len_q=s_AWLEN.
//   - Each w_hs increments beat_cnt; w_hs with s_WLAST sets w_done.
//   - AW and W may complete in either order, including in the same cycle.
//   - Move to RESP in the cycle after aw_done and w_done are both set (or both set by the current cycle).
// - RESP: the grant is held until b_hs.
//   - On b_hs: state=IDLE, both grants=0 from the next cycle; aw_done, w_done, beat_cnt cleared.
//   - This leaves at least one grant-free cycle between transactions; back-to-back grant spacing is
//     b_hs + 2 cycles.
// - Beat check: reference length L = len_q if aw_done, else the live s_AWLEN (stable under AXI while AWVALID).
//   - wlast_err pulses the cycle after a w_hs with WLAST=1 where beat_cnt != L.
//   - wlast_err also pulses after a w_hs with WLAST=0 where beat_cnt == L.
//   - In both cases state flow is unchanged: only WLAST ends the data phase.
// - beat_cnt is LEN_WIDTH+1 bits and saturates at all-ones (no wrap).
// - b_hs seen in XFER (early B, a protocol violation) is ignored; the grant is still held until RESP.
// - Grants are never both 1. Grants never change while w_busy=1.
// - ARESET mid-transaction: everything returns to reset values in the next cycle. No B wait.
// STRUCTURE
// - Shared interconnect package:
//   - typedef enum logic[1:0] {W_IDLE, W_XFER, W_RESP} w_arb_state_t
//   - localparam AXI_LEN_WIDTH = 8
// - One sub-module: axi_rr_pick2 (combinational 2-way pick from req[1:0] and last_owner, honouring RR_EN).
// - FSM, done flags, beat counter and error logic live in this module.
// TESTING
// - Reset, then m0_AWVALID=1, AWLEN=3, 4 W beats with WLAST on the 4th, then b_hs
//   -> m0_wgrnt=1 from cycle 1 through the b_hs cycle, 0 after; wlast_err never asserted.
// - m0 and m1 request in the same cycle, 3 back-to-back single-beat writes, RR_EN=1
//   -> grant order m0, m1, m0; one idle cycle between grants. With RR_EN=0 -> m0, m0, m0.
// - W completes (WLAST) 2 cycles before aw_hs
//   -> state stays XFER until aw_hs, then RESP; the grant is held throughout.
// - AWLEN=1 but WLAST on beat 0 -> wlast_err 1-cycle pulse.
//   AWLEN=0 with WLAST=0 on beat 0 -> wlast_err pulse, grant still held until WLAST.
// - ARESET asserted for 1 cycle in RESP with m_BVALID=0
//   -> next cycle both grants=0, w_busy=0; a new request is granted 1 cycle after release.
// - Random-length writes with random ready stalls
//   -> assertion: grants one-hot or zero and stable while w_busy=1.

Source files
------------

// File: rtl/axi_arbiter_w_pkg.sv
// ----------------------------------------------------------------------------
// axi_arbiter_w_pkg
// Shared definitions for the 2-master AXI interconnect write-channel arbiter.
//   w_arb_state_t  : write-arbiter FSM states (idle, data transfer, response)
//   AXI_LEN_WIDTH  : default AWLEN width used by the interconnect
// ----------------------------------------------------------------------------
package axi_arbiter_w_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } w_arb_state_t;

  localparam int AXI_LEN_WIDTH = 8;

endpackage

// File: rtl/axi_arbiter_w_rr_pick2.sv
// ----------------------------------------------------------------------------
// axi_rr_pick2
// Combinational 2-way picker used by the write-channel arbiter.
//   req[1:0]    in  : request from master 1 (bit 1) and master 0 (bit 0)
//   last_owner  in  : master that held the last grant (0 = m0, 1 = m1)
//   any_req     out : at least one request present
//   pick        out : chosen master (0 = m0, 1 = m1); only meaningful with any_req
// RR_EN = 1 gives the tie to the master that did not own the last grant;
// RR_EN = 0 always gives the tie to m0.
// ----------------------------------------------------------------------------
module axi_rr_pick2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       any_req,
  output logic       pick
);

  // A lone requester always wins; only a tie consults the priority scheme.
  always_comb begin
    any_req = |req;
    pick    = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = RR_EN ? ~last_owner : 1'b0;
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_arbiter_w.sv
// ----------------------------------------------------------------------------
// axi_arbiter_w
// Write-channel arbiter for the 2-master AXI interconnect. A grant covers one
// whole write transaction (AW handshake, all W beats, B handshake) and drives
// the downstream write-channel master mux. The W beat count is checked
// against AWLEN and mismatches are flagged.
// Ports:
//   ACLK, ARESET             clock, synchronous active-high reset
//   m0_AWVALID, m1_AWVALID   per-master write requests
//   s_AWVALID, s_AWLEN       muxed AW channel of the granted master
//   m_AWREADY                slave-side AWREADY
//   s_WVALID, s_WLAST        muxed W channel of the granted master
//   m_WREADY                 slave-side WREADY
//   m_BVALID, s_BREADY       slave-side BVALID, muxed BREADY
//   m0_wgrnt, m1_wgrnt       registered one-hot grants
//   w_busy                   transaction in flight
//   wlast_err                1-cycle pulse on a WLAST / AWLEN mismatch
// ----------------------------------------------------------------------------
module axi_arbiter_w
  import axi_arbiter_w_pkg::*;
#(
  parameter bit RR_EN     = 1'b1,
  parameter int LEN_WIDTH = AXI_LEN_WIDTH
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 m0_AWVALID,
  input  logic                 m1_AWVALID,
  input  logic                 s_AWVALID,
  input  logic [LEN_WIDTH-1:0] s_AWLEN,
  input  logic                 m_AWREADY,
  input  logic                 s_WVALID,
  input  logic                 s_WLAST,
  input  logic                 m_WREADY,
  input  logic                 m_BVALID,
  input  logic                 s_BREADY,
  output logic                 m0_wgrnt,
  output logic                 m1_wgrnt,
  output logic                 w_busy,
  output logic                 wlast_err
);

  localparam int CNT_W = LEN_WIDTH + 1;

  w_arb_state_t         state, state_nxt;
  logic                 m0_nxt, m1_nxt;
  logic                 last_owner, last_nxt;
  logic                 aw_done, aw_done_nxt;
  logic                 w_done, w_done_nxt;
  logic [CNT_W-1:0]     beat_cnt, cnt_nxt;
  logic [LEN_WIDTH-1:0] len_q, len_nxt;
  logic                 err_nxt;

  logic                 aw_hs, w_hs, b_hs;
  logic                 aw_take, beat_take;
  logic [LEN_WIDTH-1:0] len_ref;
  logic                 cnt_at_len;
  logic                 any_req, pick;

  axi_rr_pick2 #(.RR_EN(RR_EN)) u_pick (
    .req        ({m1_AWVALID, m0_AWVALID}),
    .last_owner (last_owner),
    .any_req    (any_req),
    .pick       (pick)
  );

  // Handshake decode and the reference length for the beat check. Before the
  // AW handshake the live AWLEN is used, since AXI holds it stable while
  // AWVALID is high. A second AW or extra W beats after completion of that
  // channel belong to a later transaction and are not counted here.
  always_comb begin
    aw_hs      = s_AWVALID & m_AWREADY;
    w_hs       = s_WVALID & m_WREADY;
    b_hs       = m_BVALID & s_BREADY;
    aw_take    = (state == W_XFER) & ~aw_done & aw_hs;
    beat_take  = (state == W_XFER) & ~w_done & w_hs;
    len_ref    = aw_done ? len_q : s_AWLEN;
    cnt_at_len = (beat_cnt == {1'b0, len_ref});
  end

  // Next-state logic for the FSM plus the grant, done-flag, counter and
  // error registers that travel with it. Everything holds by default; only
  // wlast_err defaults low so it can never stretch beyond one cycle.
  always_comb begin
    state_nxt   = state;
    m0_nxt      = m0_wgrnt;
    m1_nxt      = m1_wgrnt;
    last_nxt    = last_owner;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    cnt_nxt     = beat_cnt;
    len_nxt     = len_q;
    err_nxt     = 1'b0;

    case (state)
      W_IDLE: begin
        if (any_req) begin
          state_nxt = W_XFER;
          m0_nxt    = ~pick;
          m1_nxt    = pick;
          last_nxt  = pick;
        end
      end

      W_XFER: begin
        if (aw_take) begin
          aw_done_nxt = 1'b1;
          len_nxt     = s_AWLEN;
        end
        if (beat_take) begin
          if (!(&beat_cnt)) begin
            cnt_nxt = beat_cnt + CNT_W'(1);
          end
          if (s_WLAST) begin
            w_done_nxt = 1'b1;
          end
          // Early WLAST and missing WLAST are both flagged, but only WLAST
          // actually closes the data phase.
          err_nxt = s_WLAST ? ~cnt_at_len : cnt_at_len;
        end
        // An early B here is a protocol violation and is simply ignored.
        if ((aw_done | aw_take) && (w_done | (beat_take & s_WLAST))) begin
          state_nxt = W_RESP;
        end
      end

      W_RESP: begin
        if (b_hs) begin
          state_nxt   = W_IDLE;
          m0_nxt      = 1'b0;
          m1_nxt      = 1'b0;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          cnt_nxt     = '0;
        end
      end

      default: begin
        state_nxt = W_IDLE;
        m0_nxt    = 1'b0;
        m1_nxt    = 1'b0;
      end
    endcase
  end

  // State register. last_owner resets to m1 so that m0 wins the first tie.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= W_IDLE;
      m0_wgrnt   <= 1'b0;
      m1_wgrnt   <= 1'b0;
      last_owner <= 1'b1;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      beat_cnt   <= '0;
      len_q      <= '0;
      wlast_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      m0_wgrnt   <= m0_nxt;
      m1_wgrnt   <= m1_nxt;
      last_owner <= last_nxt;
      aw_done    <= aw_done_nxt;
      w_done     <= w_done_nxt;
      beat_cnt   <= cnt_nxt;
      len_q      <= len_nxt;
      wlast_err  <= err_nxt;
    end
  end

  assign w_busy = (state != W_IDLE);

endmodule
